// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC round-robin, then per-output
// input round-robin, with per-(output, VC) downstream credit counters.
module switch_allocator #(
   parameter  int PORT_NUM = 5,
   parameter  int VC_NUM   = 2,
   parameter  int CREDITS  = 8,
   localparam int VW       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   localparam int PW       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [PORT_NUM-1:0][VC_NUM-1:0]         request_i,
   input  logic [PORT_NUM-1:0][VC_NUM-1:0][2:0]    out_port_i,
   input  logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] downstream_vc_i,
   input  logic [PORT_NUM-1:0]                     credit_valid_i,
   input  logic [PORT_NUM-1:0][VW-1:0]             credit_vc_i,
   output logic [PORT_NUM-1:0][VW-1:0]             vc_sel_o,
   output logic [PORT_NUM-1:0]                     valid_sel_o,
   output logic [PORT_NUM-1:0][PW-1:0]             xb_sel_o,
   output logic [PORT_NUM-1:0]                     xb_valid_o
);

   localparam int            CW         = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

   logic [CW-1:0] credit_q  [PORT_NUM][VC_NUM];
   logic [CW-1:0] credit_d  [PORT_NUM][VC_NUM];
   logic [VW-1:0] in_ptr_q  [PORT_NUM];
   logic [VW-1:0] in_ptr_d  [PORT_NUM];
   logic [PW-1:0] out_ptr_q [PORT_NUM];
   logic [PW-1:0] out_ptr_d [PORT_NUM];

   logic [PORT_NUM-1:0][VC_NUM-1:0] eligible;

   // Stage-1 candidate per input port.
   logic [PORT_NUM-1:0] cand_valid;
   logic [VW-1:0]       cand_vc   [PORT_NUM];
   logic [PW-1:0]       cand_port [PORT_NUM];
   logic [VW-1:0]       cand_dvc  [PORT_NUM];

   // Stage-2 winner per output port.
   logic [PORT_NUM-1:0] win_valid;
   logic [PW-1:0]       win_in [PORT_NUM];

   always_comb begin
      // NOTE: every combinational output gets a default before any conditional
      // assignment, so no path leaves it unassigned and no latch is inferred.
      eligible = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (request_i[i][v] && (int'(out_port_i[i][v]) < PORT_NUM)) begin
               eligible[i][v] = (credit_q[out_port_i[i][v]][downstream_vc_i[i][v]] != '0);
            end
         end
      end
   end

   always_comb begin
      int v;
      v = 0;
      for (int i = 0; i < PORT_NUM; i++) begin
         cand_valid[i] = 1'b0;
         cand_vc[i]    = '0;
         cand_port[i]  = '0;
         cand_dvc[i]   = '0;
         for (int k = 0; k < VC_NUM; k++) begin
            v = (int'(in_ptr_q[i]) + k) % VC_NUM;
            if (!cand_valid[i] && eligible[i][v]) begin
               cand_valid[i] = 1'b1;
               cand_vc[i]    = VW'(v);
               cand_port[i]  = PW'(out_port_i[i][v]);
               cand_dvc[i]   = downstream_vc_i[i][v];
            end
         end
      end
   end

   always_comb begin
      int w;
      w = 0;
      for (int o = 0; o < PORT_NUM; o++) begin
         win_valid[o] = 1'b0;
         win_in[o]    = '0;
         for (int k = 0; k < PORT_NUM; k++) begin
            w = (int'(out_ptr_q[o]) + k) % PORT_NUM;
            if (!win_valid[o] && cand_valid[w] && (int'(cand_port[w]) == o)) begin
               win_valid[o] = 1'b1;
               win_in[o]    = PW'(w);
            end
         end
      end
   end

   always_comb begin
      valid_sel_o = '0;
      vc_sel_o    = '0;
      xb_sel_o    = '0;
      xb_valid_o  = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         if (win_valid[o]) begin
            xb_valid_o[o]            = 1'b1;
            xb_sel_o[o]              = win_in[o];
            valid_sel_o[win_in[o]]   = 1'b1;
            vc_sel_o[win_in[o]]      = cand_vc[win_in[o]];
         end
      end
   end

   // Pointers move only for stage-2 winners; a grant and a returned credit on the
   // same counter cancel, and returns at full depth are dropped.
   always_comb begin
      logic dec;
      logic inc;
      dec       = 1'b0;
      inc       = 1'b0;
      credit_d  = credit_q;
      in_ptr_d  = in_ptr_q;
      out_ptr_d = out_ptr_q;
      for (int o = 0; o < PORT_NUM; o++) begin
         if (win_valid[o]) begin
            out_ptr_d[o]      = PW'((int'(win_in[o]) + 1) % PORT_NUM);
            in_ptr_d[win_in[o]] = VW'((int'(cand_vc[win_in[o]]) + 1) % VC_NUM);
         end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            dec = win_valid[o] && (cand_dvc[win_in[o]] == VW'(v));
            inc = credit_valid_i[o] && (credit_vc_i[o] == VW'(v));
            if (dec && !inc) begin
               credit_d[o][v] = credit_q[o][v] - CW'(1);
            end else if (inc && !dec && (credit_q[o][v] != CREDIT_MAX)) begin
               credit_d[o][v] = credit_q[o][v] + CW'(1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the credit array is real protocol state, not a data buffer, so
         // every entry must be reset to full depth.
         for (int o = 0; o < PORT_NUM; o++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               credit_q[o][v] <= CREDIT_MAX;
            end
            in_ptr_q[o]  <= '0;
            out_ptr_q[o] <= '0;
         end
      end else begin
         credit_q  <= credit_d;
         in_ptr_q  <= in_ptr_d;
         out_ptr_q <= out_ptr_d;
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Randomised and directed bench for switch_allocator against a distance-based
// round-robin reference model with integer credit counters.
module tb_switch_allocator;

   localparam int PORT_NUM = 5;
   localparam int VC_NUM   = 2;
   localparam int CREDITS  = 8;
   localparam int VW       = 1;
   localparam int PW       = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [PORT_NUM-1:0][VC_NUM-1:0]         request;
   logic [PORT_NUM-1:0][VC_NUM-1:0][2:0]    out_port;
   logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] downstream_vc;
   logic [PORT_NUM-1:0]                     credit_valid;
   logic [PORT_NUM-1:0][VW-1:0]             credit_vc;
   logic [PORT_NUM-1:0][VW-1:0]             vc_sel;
   logic [PORT_NUM-1:0]                     valid_sel;
   logic [PORT_NUM-1:0][PW-1:0]             xb_sel;
   logic [PORT_NUM-1:0]                     xb_valid;

   int checks = 0;
   int errors = 0;

   // Reference model state and per-cycle expectations.
   int  m_credit  [PORT_NUM][VC_NUM];
   int  m_in_ptr  [PORT_NUM];
   int  m_out_ptr [PORT_NUM];
   bit  m_ready = 1'b0;
   logic [PORT_NUM-1:0][VW-1:0] e_vc_sel;
   logic [PORT_NUM-1:0]         e_valid_sel;
   logic [PORT_NUM-1:0][PW-1:0] e_xb_sel;
   logic [PORT_NUM-1:0]         e_xb_valid;
   int  e_dvc [PORT_NUM];

   switch_allocator #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM), .CREDITS(CREDITS)) dut (
      .clk             (clk),
      .rst             (rst),
      .request_i       (request),
      .out_port_i      (out_port),
      .downstream_vc_i (downstream_vc),
      .credit_valid_i  (credit_valid),
      .credit_vc_i     (credit_vc),
      .vc_sel_o        (vc_sel),
      .valid_sel_o     (valid_sel),
      .xb_sel_o        (xb_sel),
      .xb_valid_o      (xb_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_eligible(int i, int v);
      int o;
      int d;
      o = int'(out_port[i][v]);
      d = int'(downstream_vc[i][v]);
      if (!request[i][v] || o >= PORT_NUM) return 1'b0;
      return m_credit[o][d] > 0;
   endfunction

   // Round-robin expressed as "smallest forward distance from the pointer".
   function automatic void compute_expected();
      int cand_v [PORT_NUM];
      int cand_o [PORT_NUM];
      int best;
      int d;
      int wb;
      e_vc_sel    = '0;
      e_valid_sel = '0;
      e_xb_sel    = '0;
      e_xb_valid  = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         cand_v[i] = -1;
         cand_o[i] = -1;
         best      = VC_NUM;
         for (int v = 0; v < VC_NUM; v++) begin
            d = (v - m_in_ptr[i] + VC_NUM) % VC_NUM;
            if (model_eligible(i, v) && d < best) begin
               best      = d;
               cand_v[i] = v;
            end
         end
         if (cand_v[i] >= 0) cand_o[i] = int'(out_port[i][cand_v[i]]);
      end
      for (int o = 0; o < PORT_NUM; o++) begin
         wb   = -1;
         best = PORT_NUM;
         e_dvc[o] = 0;
         for (int w = 0; w < PORT_NUM; w++) begin
            d = (w - m_out_ptr[o] + PORT_NUM) % PORT_NUM;
            if (cand_o[w] == o && d < best) begin
               best = d;
               wb   = w;
            end
         end
         if (wb >= 0) begin
            e_xb_valid[o]   = 1'b1;
            e_xb_sel[o]     = PW'(wb);
            e_valid_sel[wb] = 1'b1;
            e_vc_sel[wb]    = VW'(cand_v[wb]);
            e_dvc[o]        = int'(downstream_vc[wb][cand_v[wb]]);
         end
      end
   endfunction

   function automatic void model_advance();
      int w;
      int c;
      if (rst) begin
         for (int o = 0; o < PORT_NUM; o++) begin
            for (int v = 0; v < VC_NUM; v++) m_credit[o][v] = CREDITS;
            m_in_ptr[o]  = 0;
            m_out_ptr[o] = 0;
         end
         m_ready = 1'b1;
         return;
      end
      if (!m_ready) return;
      compute_expected();
      for (int o = 0; o < PORT_NUM; o++) begin
         if (e_xb_valid[o]) begin
            w = int'(e_xb_sel[o]);
            m_credit[o][e_dvc[o]] = m_credit[o][e_dvc[o]] - 1;
            m_out_ptr[o] = (w + 1) % PORT_NUM;
            m_in_ptr[w]  = (int'(e_vc_sel[w]) + 1) % VC_NUM;
         end
      end
      for (int p = 0; p < PORT_NUM; p++) begin
         if (credit_valid[p]) begin
            c = int'(credit_vc[p]);
            m_credit[p][c] = (m_credit[p][c] + 1 > CREDITS) ? CREDITS : m_credit[p][c] + 1;
         end
      end
   endfunction

   always @(posedge clk) model_advance();

   always @(negedge clk) begin
      if (m_ready) begin
         compute_expected();
         check("valid_sel", 32'(valid_sel), 32'(e_valid_sel));
         check("vc_sel",    32'(vc_sel),    32'(e_vc_sel));
         check("xb_valid",  32'(xb_valid),  32'(e_xb_valid));
         check("xb_sel",    32'(xb_sel),    32'(e_xb_sel));
      end
   end

   task automatic clear_inputs();
      request       = '0;
      out_port      = '0;
      downstream_vc = '0;
      credit_valid  = '0;
      credit_vc     = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      int g;
      int cnt [PORT_NUM];
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      @(negedge clk);
      check("reset_valid_sel", 32'(valid_sel), 32'd0);
      check("reset_xb_valid",  32'(xb_valid),  32'd0);
      check("reset_vc_sel",    32'(vc_sel),    32'd0);
      check("reset_xb_sel",    32'(xb_sel),    32'd0);
      next_cycle();
      rst = 1'b0;

      // LOCAL VC1 -> EAST, downstream VC0: 8 grants then stall.
      request[0][1]       = 1'b1;
      out_port[0][1]      = 3'd4;
      downstream_vc[0][1] = 1'b0;
      g = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check("t1_valid_sel0", 32'(valid_sel[0]), 32'd1);
         check("t1_vc_sel0",    32'(vc_sel[0]),    32'd1);
         check("t1_xb_sel4",    32'(xb_sel[4]),    32'd0);
         g += int'(xb_valid[4]);
         next_cycle();
      end
      check("t1_grant_count", 32'(g), 32'd8);
      @(negedge clk);
      check("t1_exhausted", 32'(xb_valid[4]), 32'd0);
      check("t1_model_credit", 32'(m_credit[4][0]), 32'd0);

      // One credit back: one grant exactly the next cycle, then stall again.
      next_cycle();
      credit_valid[4] = 1'b1;
      credit_vc[4]    = 1'b0;
      @(negedge clk);
      check("t2_no_grant_same_cycle", 32'(xb_valid[4]), 32'd0);
      next_cycle();
      credit_valid[4] = 1'b0;
      @(negedge clk);
      check("t2_grant_after_credit", 32'(valid_sel[0]), 32'd1);
      next_cycle();
      @(negedge clk);
      check("t2_stall_again", 32'(xb_valid[4]), 32'd0);
      check("t2_model_credit", 32'(m_credit[4][0]), 32'd0);
      clear_inputs();
      next_cycle();

      // Inputs 1..3 contend for EAST (downstream VC1), credits replenished every cycle.
      for (int i = 0; i < PORT_NUM; i++) cnt[i] = 0;
      for (int i = 1; i <= 3; i++) begin
         request[i][0]       = 1'b1;
         out_port[i][0]      = 3'd4;
         downstream_vc[i][0] = 1'b1;
      end
      credit_valid[4] = 1'b1;
      credit_vc[4]    = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         check("t3_xb_sel4", 32'(xb_sel[4]), 32'(1 + n % 3));
         for (int i = 0; i < PORT_NUM; i++) cnt[i] += int'(valid_sel[i]);
         next_cycle();
      end
      check("t3_count_in1", 32'(cnt[1]), 32'd2);
      check("t3_count_in2", 32'(cnt[2]), 32'd2);
      check("t3_count_in3", 32'(cnt[3]), 32'd2);
      clear_inputs();
      do_reset();

      // Input 2, both VCs -> NORTH with distinct downstream VCs.
      request[2]          = 2'b11;
      out_port[2][0]      = 3'd1;
      out_port[2][1]      = 3'd1;
      downstream_vc[2][0] = 1'b0;
      downstream_vc[2][1] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("t4_vc_alternate", 32'(vc_sel[2]), 32'(n % 2));
         next_cycle();
      end
      clear_inputs();

      // SOUTH VC0 down to 3, then grant and credit together: still 3.
      request[0][0]  = 1'b1;
      out_port[0][0] = 3'd2;
      for (int n = 0; n < 5; n++) next_cycle();
      check("t5_model_credit3", 32'(m_credit[2][0]), 32'd3);
      credit_valid[2] = 1'b1;
      credit_vc[2]    = 1'b0;
      @(negedge clk);
      check("t5_grant_with_credit", 32'(xb_valid[2]), 32'd1);
      next_cycle();
      credit_valid[2] = 1'b0;
      g = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         g += int'(xb_valid[2]);
         next_cycle();
      end
      check("t5_grants_left", 32'(g), 32'd3);
      clear_inputs();

      // Credit return into a full WEST VC0 counter is dropped.
      credit_valid[3] = 1'b1;
      credit_vc[3]    = 1'b0;
      next_cycle();
      clear_inputs();
      request[0][0]  = 1'b1;
      out_port[0][0] = 3'd3;
      g = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         g += int'(xb_valid[3]);
         next_cycle();
      end
      check("t6_full_credit_grants", 32'(g), 32'd8);
      clear_inputs();

      // Out-of-range out_port is never granted.
      request[1]     = 2'b11;
      out_port[1][0] = 3'd7;
      out_port[1][1] = 3'd7;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("t7_port7_valid_sel", 32'(valid_sel[1]), 32'd0);
         check("t7_port7_xb_valid",  32'(xb_valid),     32'd0);
         next_cycle();
      end
      clear_inputs();

      // Reset mid-stream after EAST pointer advanced.
      for (int i = 1; i <= 3; i++) begin
         request[i][0]       = 1'b1;
         out_port[i][0]      = 3'd4;
         downstream_vc[i][0] = 1'b1;
      end
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("t8_lowest_wins", 32'(xb_sel[4]), 32'd1);
      check("t8_model_ptr",   32'(m_out_ptr[4]), 32'd0);
      check("t8_model_credit", 32'(m_credit[4][1]), 32'd8);
      next_cycle();
      clear_inputs();

      // Randomised traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               request[i][v]       = ($urandom_range(0, 9) < 6);
               out_port[i][v]      = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
               downstream_vc[i][v] = VW'($urandom_range(0, 1));
            end
            credit_valid[i] = ($urandom_range(0, 9) < 3);
            credit_vc[i]    = VW'($urandom_range(0, 1));
         end
         rst = ($urandom_range(0, 499) == 0);
         next_cycle();
      end
      rst = 1'b0;
      clear_inputs();
      next_cycle();
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Separable input-first switch allocator for one router: grants per cycle at most one VC per input port and at most one input port per output port. It tracks downstream buffer credits per output port and VC. It sits directly downstream of the router's input ports: it consumes their per-VC requests and routing results, returns the VC selection that drives each input port's crossbar read, and drives the crossbar select lines.

## Interface
Parameters:
- PORT_NUM, 5, router ports; port_t encoding LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4
- VC_NUM, 2, virtual channels per port
- CREDITS, 8, downstream buffer depth per VC; equals downstream BUFFER_SIZE

Ports (VW = $clog2(VC_NUM), PW = $clog2(PORT_NUM)):
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- request_i  in  [PORT_NUM][VC_NUM]  VC has a buffered flit and a valid downstream VC
- out_port_i  in  [PORT_NUM][VC_NUM] port_t (3)  routed output port of that VC
- downstream_vc_i  in  [PORT_NUM][VC_NUM][VW]  downstream VC allocated to that VC
- credit_valid_i  in  [PORT_NUM]  one credit returned on output port p
- credit_vc_i  in  [PORT_NUM][VW]  VC of the returned credit
- vc_sel_o  out  [PORT_NUM][VW]  VC to read on input port i
- valid_sel_o  out  [PORT_NUM]  input port i granted this cycle; read enable
- xb_sel_o  out  [PORT_NUM][PW]  input port driving output port o
- xb_valid_o  out  [PORT_NUM]  output port o carries a flit this cycle

## Operation
- State: credit[o][v] (width $clog2(CREDITS+1)), in_ptr[i] (VW), out_ptr[o] (PW). No other state.
- Eligibility: VC (i,v) is eligible when request_i[i][v]=1, out_port_i[i][v] < PORT_NUM, and credit[out_port][downstream_vc] > 0. A request with out_port ≥ PORT_NUM is ignored.
- Stage 1, per input port: round-robin among eligible VCs, starting the search at in_ptr[i]. This produces one candidate (i, v_i, o_i).
- Stage 2, per output port o: round-robin among input ports whose candidate targets o, starting the search at out_ptr[o]. The winner w sets xb_sel_o[o]=w, xb_valid_o[o]=1, valid_sel_o[w]=1, vc_sel_o[w]=v_w.
- Pointer update, only on stage-2 grant: out_ptr[o] ← (w+1) mod PORT_NUM; in_ptr[w] ← (v_w+1) mod VC_NUM. A stage-1 loser keeps its in_ptr.
- Credits: each grant decrements credit[o][downstream_vc] by 1. Each credit_valid_i[p] increments credit[p][credit_vc_i[p]] by 1.
- Simultaneous grant and credit on the same counter: net unchanged.
- Credit return with counter already at CREDITS: counter holds at CREDITS; this is a protocol error and is not flagged.
- Ungranted ports: vc_sel_o, xb_sel_o = 0; valid flags = 0.

## Timing
- Grants are combinational from current inputs and registered state. Zero-cycle allocation: the input port reads data[vc_sel_o] in the same cycle valid_sel_o=1.
- All state updates on rising clk. A decremented credit blocks a request already in the cycle after the grant. A returned credit enables a request in the cycle after credit_valid_i.
- Reset values: credit = CREDITS, all pointers = 0. With request_i = 0 during reset, all outputs = 0.
- rst asserted mid-operation: state is re-initialised at that edge; grants issued in the reset cycle do not update state.
- Throughput: one flit per output port per cycle. A VC with one credit left gets one grant, then stalls until its credit returns.

## Test plan
- Reset then single request, input 0 (LOCAL) VC1 → EAST, downstream VC 0: same cycle valid_sel_o[0]=1, vc_sel_o[0]=1, xb_sel_o[4]=0, xb_valid_o[4]=1. Held for 8 cycles: 8 grants; cycle 9: no grant.
- Credit return: after exhaustion, pulse credit_valid_i[4]=1 with credit_vc_i=0 → one grant exactly one cycle later; counter back to 0 afterwards.
- Output contention: inputs 1, 2, 3 request EAST continuously with ample credits → xb_sel_o[4] cycles 1,2,3,1,2,3; each input gets exactly one grant per 3 cycles.
- VC fairness: input 2, both VCs → NORTH with different downstream VCs → vc_sel_o[2] alternates 0,1,0,1.
- Simultaneous grant and credit on the same counter at value 3 → counter stays 3. Credit return at value 8 → counter stays 8. Out_port 7 request → never granted.
- Reset mid-stream after pointers advanced → next cycle pointers 0, credits 8; lowest-index eligible requester wins.
